sha_wb_master: RTL
==================

SHA_WB_MASTER -- requirements
Module: sha_wb_master

Interface
REQ-001 The block SHALL have parameter BASE_ADR, default 32'h3000_0000, giving the Wishbone address driven on every transaction.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles one transaction may wait for ack (range 1..255).
REQ-003 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-005 blk_we  in  1  load strobe into the 16x32 block buffer.
REQ-006 blk_idx  in  4  buffer word index for blk_we.
REQ-007 blk_wdata  in  32  buffer write data.
REQ-008 start  in  1  single-cycle request to run one hash job.
REQ-009 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-010 wbm_sel_o  out  4  byte selects.
REQ-011 wbm_adr_o  out  32  address.
REQ-012 wbm_dat_o  out  32  write data.
REQ-013 wbm_dat_i  in  32  read data.
REQ-014 wbm_ack_i  in  1  slave acknowledge.
REQ-015 busy  out  1  high outside IDLE.
REQ-016 done  out  1  one-cycle pulse on successful completion.
REQ-017 timeout_err  out  1  sticky error flag.
REQ-018 digest_o  out  256  collected digest, word 0 in bits [255:224].

Function
REQ-019 States SHALL be IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP; word counter wcnt is 4 bits.
REQ-020 blk_we SHALL write blk_wdata to buffer[blk_idx] only while busy=0; ignored while busy=1.
REQ-021 In IDLE, start=1 SHALL clear timeout_err, set wcnt=0, enter WR_REQ next cycle; start in any other state SHALL be ignored.
REQ-022 In WR_REQ: cyc=stb=we=1, sel=4'hF, adr=BASE_ADR, dat_o=buffer[wcnt], all held stable until ack.
REQ-023 On ack in WR_REQ: cyc=stb=0 next cycle (WR_GAP, exactly one cycle); wcnt<15 -> wcnt+1, WR_REQ; wcnt=15 -> wcnt=0, RD_REQ.
REQ-024 In RD_REQ: cyc=stb=1, we=0, sel=4'h0, adr=BASE_ADR, dat_o=0.
REQ-025 On ack in RD_REQ: wbm_dat_i SHALL be latched into digest_o[255-32*wcnt -: 32] the same edge; then RD_GAP (one cycle); wcnt<7 -> wcnt+1, RD_REQ; wcnt=7 -> IDLE with done=1 for exactly one cycle.
REQ-026 Outside WR_REQ/RD_REQ: cyc=stb=we=0, sel=0, dat_o=0, adr=BASE_ADR; wbm_ack_i SHALL be ignored.
REQ-027 A per-transaction 8-bit counter SHALL clear on entering WR_REQ/RD_REQ and increment each cycle without ack; reaching TIMEOUT without ack -> drop cyc/stb next cycle, set timeout_err=1, return to IDLE, no done pulse, digest_o keeps words already latched.
REQ-028 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-029 A full successful job SHALL take exactly 48 cycles from start with zero-wait-state ack (24 transactions x 2 cycles), done asserted on cycle 49.
REQ-030 digest_o SHALL change only on read acks; it is not cleared by start.

Reset
REQ-031 wb_rst_i=1 SHALL asynchronously force IDLE, wcnt=0, timeout counter=0, all Wishbone outputs as in REQ-026, busy=0, done=0, timeout_err=0, digest_o=0; buffer contents need not reset.
REQ-032 Reset asserted mid-transaction SHALL drop cyc/stb immediately (combinationally via state), with no done pulse after release.

Verification
REQ-033 Load buffer[i]=32'h1000_0000+i, start, zero-wait ack -> 16 writes with dat_o 32'h1000_0000..32'h1000_000F in order, then 8 reads; done on cycle 49.
REQ-034 Reads return 32'hA0+k for k=0..7 -> digest_o[255:224]=32'hA0 ... digest_o[31:0]=32'hA7, done=1 one cycle.
REQ-035 Ack delayed 3 cycles on write 5 -> stb, adr, dat_o=buffer[5] stable for 4 cycles; no skipped or repeated word.
REQ-036 TIMEOUT=4, never ack read 2 -> cyc drops after 4 cycles, timeout_err=1, busy=0, no done; digest words 0,1 retained; next start clears timeout_err.
REQ-037 start and blk_we pulsed during WR_REQ -> ignored; buffer and sequence unchanged.
REQ-038 wb_rst_i asserted during write 9 -> cyc=stb=0 same cycle, busy=0, digest_o=0; after release no bus activity until start.

Source files
------------

// File: rtl/sha_wb_master.sv
// Wishbone classic master that streams a 16-word block out to a hash core
// and reads back an 8-word digest, with a per-transaction ack timeout.
module sha_wb_master #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         blk_we,
    input  logic [3:0]   blk_idx,
    input  logic [31:0]  blk_wdata,
    input  logic         start,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [255:0] digest_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [3:0]   wcnt_q, wcnt_d;
    logic [7:0]   tcnt_q, tcnt_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic [255:0] digest_q, digest_d;
    logic [31:0]  buf_q [16];
    logic [2:0]   rd_slot;

    // Word 0 lands in the top 32 bits of the digest.
    assign rd_slot = 3'd7 - wcnt_q[2:0];

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        digest_d = digest_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    wcnt_d  = 4'd0;
                    tcnt_d  = 8'd0;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (wbm_ack_i) begin
                    state_d = S_WR_GAP;
                end else if (tcnt_q == TLAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_WR_GAP: begin
                tcnt_d = 8'd0;
                if (wcnt_q == 4'd15) begin
                    wcnt_d  = 4'd0;
                    state_d = S_RD_REQ;
                end else begin
                    wcnt_d  = wcnt_q + 4'd1;
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ: begin
                if (wbm_ack_i) begin
                    digest_d[{rd_slot, 5'b0} +: 32] = wbm_dat_i;
                    state_d = S_RD_GAP;
                end else if (tcnt_q == TLAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_RD_GAP: begin
                tcnt_d = 8'd0;
                if (wcnt_q == 4'd7) begin
                    wcnt_d  = 4'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 4'd1;
                    state_d = S_RD_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 4'd0;
            tcnt_q   <= 8'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (blk_we && state_q == S_IDLE) begin
            buf_q[blk_idx] <= blk_wdata;
        end
    end

    always_comb begin
        wbm_cyc_o = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
        wbm_stb_o = wbm_cyc_o;
        wbm_we_o  = (state_q == S_WR_REQ);
        wbm_sel_o = wbm_we_o ? 4'hF : 4'h0;
        wbm_adr_o = BASE_ADR;
        wbm_dat_o = wbm_we_o ? buf_q[wcnt_q] : 32'h0;
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign timeout_err = err_q;
    assign digest_o    = digest_q;

endmodule
